// File: rtl/sign_extension.sv
// sign_extension: registered immediate extender for the ID stage.
// Widens an IN_W-bit immediate to OUT_W bits by sign-extend, zero-extend
// or load-upper, and also registers the word-aligned branch offset.
// Optional feature macro: SIGNEXT_LUI_EN enables the load-upper mode (10).
// Without it, mode 10 behaves as sign-extend and the LUI leg is not built.
module sign_extension #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  Input,
  output logic             out_valid,
  output logic [OUT_W-1:0] Output,
  output logic [OUT_W-1:0] branch_off,
  output logic             sign_bit
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] ext_next;
  logic [OUT_W-1:0] branch_next;

  // Select the extension rule; the default leg (sign-extend) also absorbs
  // modes 00/11 and any unknown mode so X never reaches the registers.
  always_comb begin
    ext_next = {{EXT_W{Input[IN_W-1]}}, Input};
    case (mode)
      2'b01:   ext_next = {{EXT_W{1'b0}}, Input};
`ifdef SIGNEXT_LUI_EN
      2'b10:   ext_next = {Input, {EXT_W{1'b0}}};
`endif
      default: ext_next = {{EXT_W{Input[IN_W-1]}}, Input};
    endcase
  end

  // Branch offset is the extended value in words; the top two bits drop off.
  always_comb begin
    branch_next = {ext_next[OUT_W-3:0], 2'b00};
  end

  // Pipeline register: flush beats stall, stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      Output     <= '0;
      branch_off <= '0;
      sign_bit   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      Output     <= '0;
      branch_off <= '0;
      sign_bit   <= 1'b0;
    end else if (en) begin
      out_valid  <= in_valid;
      Output     <= ext_next;
      branch_off <= branch_next;
      sign_bit   <= Input[IN_W-1];
    end
  end

endmodule

// File: tb/tb_sign_extension.sv
// tb_sign_extension: directed and randomized checks of sign_extension
// against an arithmetic reference model of the extension rules.
module tb_sign_extension;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [1:0]  mode;
  logic [15:0] Input;
  logic        out_valid;
  logic [31:0] Output;
  logic [31:0] branch_off;
  logic        sign_bit;

  int checks;
  int failures;

  logic        exp_valid;
  logic [31:0] exp_out;
  logic [31:0] exp_br;
  logic        exp_sign;

  sign_extension #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .mode(mode), .Input(Input), .out_valid(out_valid), .Output(Output),
    .branch_off(branch_off), .sign_bit(sign_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extension computed as signed/unsigned arithmetic on the value.
  function automatic logic [31:0] model_ext(input logic [1:0] m, input logic [15:0] v);
    int unsigned u;
    int          s;
    u = v;
    s = (u >= 32768) ? int'(u) - 65536 : int'(u);
    if (m == 2'b01) return u;
`ifdef SIGNEXT_LUI_EN
    if (m == 2'b10) return u * 65536;
`endif
    return s;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the expected state.
  task automatic applyStimulus(input logic e, input logic f, input logic v,
                               input logic [1:0] m, input logic [15:0] d);
    logic [1:0]  mm;
    logic [31:0] ext;
    en = e; flush = f; in_valid = v; mode = m; Input = d;
    mm = $isunknown(m) ? 2'b00 : m;
    ext = model_ext(mm, d);
    @(posedge clk);
    #1;
    if (f) begin
      exp_valid = 1'b0; exp_out = '0; exp_br = '0; exp_sign = 1'b0;
    end else if (e) begin
      exp_valid = v; exp_out = ext; exp_br = ext * 32'd4; exp_sign = (d >= 16'h8000);
    end
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_out = '0; exp_br = '0; exp_sign = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; mode = 2'b00; Input = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, Output, branch_off, sign_bit} !== 66'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got v=%0b out=%h br=%h s=%0b, want all 0",
               out_valid, Output, branch_off, sign_bit);
    end
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'h0000);
    checks++;
    if (Output !== 32'h0 || branch_off !== 32'h0 || sign_bit !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_first_load: got out=%h br=%h s=%0b v=%0b, want 0/0/0/1",
               Output, branch_off, sign_bit, out_valid);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'h81C0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_valid, Output, branch_off, sign_bit} !== 66'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got v=%0b out=%h br=%h s=%0b, want all 0",
               out_valid, Output, branch_off, sign_bit);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 16'h1234);
    checks++;
    if ({out_valid, Output, branch_off, sign_bit} !== 66'd0) begin
      failures++;
      $display("[TB] FAIL reset_release_stall: got out=%h v=%0b, want 0/0", Output, out_valid);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'h1234);
    checks++;
    if (Output !== 32'h00001234) begin
      failures++;
      $display("[TB] FAIL reset_release_load: got %h, want 00001234", Output);
    end
  endtask

  task automatic test_sign_extend();
    logic [15:0] ins [3];
    logic [31:0] outs [3];
    logic [31:0] brs [3];
    logic        sbs [3];
    ins  = '{16'h6424, 16'h81C0, 16'h0000};
    outs = '{32'h00006424, 32'hFFFF81C0, 32'h00000000};
    brs  = '{32'h00019090, 32'hFFFE0700, 32'h00000000};
    sbs  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, ins[i]);
      checks++;
      if (Output !== outs[i] || branch_off !== brs[i] || sign_bit !== sbs[i] || out_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL sign_ext_%h: got out=%h br=%h s=%0b v=%0b, want %h %h %0b 1",
                 ins[i], Output, branch_off, sign_bit, out_valid, outs[i], brs[i], sbs[i]);
      end
    end
  endtask

  task automatic test_zero_and_lui();
    logic [31:0] lui_want;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 16'h81C0);
    checks++;
    if (Output !== 32'h000081C0 || branch_off !== 32'h00020700 || sign_bit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_ext: got out=%h br=%h s=%0b, want 000081C0 00020700 1",
               Output, branch_off, sign_bit);
    end
`ifdef SIGNEXT_LUI_EN
    lui_want = 32'h12340000;
`else
    lui_want = 32'h00001234;
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 16'h1234);
    checks++;
    if (Output !== lui_want || branch_off !== (lui_want << 2) || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mode10: got out=%h br=%h v=%0b, want %h %h 0",
               Output, branch_off, out_valid, lui_want, lui_want << 2);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'bxx, 16'h8001);
    checks++;
    if (Output !== 32'hFFFF8001) begin
      failures++;
      $display("[TB] FAIL mode_x: got %h, want FFFF8001", Output);
    end
  endtask

  task automatic test_stall();
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'h81C0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 16'h0001);
      checks++;
      if (Output !== 32'hFFFF81C0 || branch_off !== 32'hFFFE0700 || out_valid !== 1'b1 || sign_bit !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d: got out=%h br=%h v=%0b, want FFFF81C0 FFFE0700 1",
                 i, Output, branch_off, out_valid);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'h0001);
    checks++;
    if (Output !== 32'h00000001 || branch_off !== 32'h00000004) begin
      failures++;
      $display("[TB] FAIL stall_release: got out=%h br=%h, want 00000001 00000004", Output, branch_off);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 16'h7FFF);
    checks++;
    if ({out_valid, Output, branch_off, sign_bit} !== 66'd0) begin
      failures++;
      $display("[TB] FAIL flush_over_stall: got v=%0b out=%h br=%h s=%0b, want all 0",
               out_valid, Output, branch_off, sign_bit);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 16'h7FFF);
    checks++;
    if (Output !== 32'h00007FFF || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_recover: got out=%h v=%0b, want 00007FFF 1", Output, out_valid);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 16'h1111);
    checks++;
    if (Output !== 32'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_over_load: got out=%h v=%0b, want 0 0", Output, out_valid);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] ins [3];
    logic [1:0]  modes [3];
    logic [31:0] want [3][3];
    ins   = '{16'h7FFF, 16'h8000, 16'hFFFF};
    modes = '{2'b00, 2'b01, 2'b11};
    want  = '{'{32'h00007FFF, 32'h00007FFF, 32'h00007FFF},
              '{32'hFFFF8000, 32'h00008000, 32'hFFFF8000},
              '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF}};
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b1, 1'b0, 1'b1, modes[j], ins[i]);
        checks++;
        if (Output !== want[i][j] || branch_off !== (want[i][j] << 2) || sign_bit !== ins[i][15]) begin
          failures++;
          $display("[TB] FAIL boundary_%h_m%0d: got out=%h br=%h s=%0b, want %h %h %0b",
                   ins[i], modes[j], Output, branch_off, sign_bit, want[i][j], want[i][j] << 2, ins[i][15]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom),
                    2'($urandom), 16'($urandom));
      checks++;
      if (out_valid !== exp_valid || Output !== exp_out || branch_off !== exp_br || sign_bit !== exp_sign) begin
        failures++;
        $display("[TB] FAIL random_%0d: got v=%0b out=%h br=%h s=%0b, want v=%0b out=%h br=%h s=%0b",
                 i, out_valid, Output, branch_off, sign_bit, exp_valid, exp_out, exp_br, exp_sign);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sign_extend();
    test_zero_and_lui();
    test_stall();
    test_flush();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
